// File: rtl/prep_mem_nch.sv
// Multi-channel memory preparation stage: delays NCH word streams by LATENCY,
// drops sentinel words and produces event-paged write addresses per channel.
module prep_mem_nch #(
  parameter int INPUT_SIZE   = 36,
  parameter int NCH          = 2,
  parameter int LATENCY      = 4,
  parameter int ADDR_WIDTH   = 6,
  parameter int FILTER_ONES  = 1,
  parameter int FILTER_ZEROS = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en_proc,
  input  logic [1:0]                     start,
  output logic [1:0]                     done,
  input  logic [NCH*INPUT_SIZE-1:0]      data_in,
  output logic [NCH*INPUT_SIZE-1:0]      data_out,
  output logic [NCH-1:0]                 wr_en,
  output logic [NCH*(ADDR_WIDTH+2)-1:0]  wr_addr,
  output logic [NCH-1:0]                 overflow
);

  localparam int          DW  = NCH * INPUT_SIZE;
  localparam int          AW2 = ADDR_WIDTH + 2;
  localparam int unsigned STG = LATENCY - 1;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DW-1:0]     data_q [STG];
  logic [NCH-1:0]    vld_q  [STG];
  logic [1:0]        page_q [STG];
  logic [NCH-1:0]    valid_d;

  logic [1:0]        done_q;
  logic [DW-1:0]     data_out_q;
  logic [NCH-1:0]    wr_en_q, wr_en_d;
  logic [NCH*AW2-1:0] wr_addr_q, wr_addr_d;
  logic [NCH-1:0]    ovf_q, ovf_d;
  logic [ADDR_WIDTH:0] cnt_q [NCH];
  logic [ADDR_WIDTH:0] cnt_d [NCH];
  logic              boundary;

  always_comb begin
    valid_d = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      valid_d[c] = en_proc
        && !((FILTER_ONES != 0)  && (&data_in[c*INPUT_SIZE +: INPUT_SIZE]))
        && !((FILTER_ZEROS != 0) && (data_in[c*INPUT_SIZE +: INPUT_SIZE] == '0));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < STG; i++) begin
        data_q[i] <= '0;
        vld_q[i]  <= '0;
        page_q[i] <= '0;
      end
    end else begin
      data_q[0] <= data_in;
      vld_q[0]  <= valid_d;
      page_q[0] <= start;
      for (int unsigned i = 1; i < STG; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
        page_q[i] <= page_q[i-1];
      end
    end
  end

  // done_q doubles as the last-output-page register: both always hold the
  // page of the most recent output cycle.
  always_comb begin
    boundary  = (page_q[STG-1] != done_q);
    wr_en_d   = '0;
    wr_addr_d = wr_addr_q;
    ovf_d     = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      cnt_d[c] = boundary ? '0 : cnt_q[c];
      ovf_d[c] = boundary ? 1'b0 : ovf_q[c];
      if (vld_q[STG-1][c]) begin
        if (cnt_d[c] < DEPTH) begin
          wr_en_d[c]              = 1'b1;
          wr_addr_d[c*AW2 +: AW2] = {page_q[STG-1], cnt_d[c][ADDR_WIDTH-1:0]};
          cnt_d[c]                = cnt_d[c] + (ADDR_WIDTH+1)'(1);
        end else begin
          ovf_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q     <= '0;
      data_out_q <= '0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      ovf_q      <= '0;
      for (int unsigned c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else begin
      done_q     <= page_q[STG-1];
      data_out_q <= data_q[STG-1];
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      ovf_q      <= ovf_d;
      for (int unsigned c = 0; c < NCH; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign done     = done_q;
  assign data_out = data_out_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_prep_mem_nch.sv
// Directed bench for prep_mem_nch: three instances cover default filtering,
// FILTER_ZEROS=0 and a shallow ADDR_WIDTH=2 event for overflow behaviour.
module tb_prep_mem_nch;

  logic        clk = 1'b0;
  logic        reset;
  logic        en_proc;
  logic [1:0]  start;
  logic [71:0] data_in;

  logic [1:0]  done_a, done_b, done_c;
  logic [71:0] dout_a, dout_b, dout_c;
  logic [1:0]  we_a, we_b, we_c;
  logic [15:0] wa_a, wa_b;
  logic [7:0]  wa_c;
  logic [1:0]  ovf_a, ovf_b, ovf_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prep_mem_nch #(.INPUT_SIZE(36), .NCH(2), .LATENCY(4), .ADDR_WIDTH(6),
                 .FILTER_ONES(1), .FILTER_ZEROS(1)) u_dut_a (
    .clk(clk), .reset(reset), .en_proc(en_proc), .start(start), .done(done_a),
    .data_in(data_in), .data_out(dout_a), .wr_en(we_a), .wr_addr(wa_a),
    .overflow(ovf_a));

  prep_mem_nch #(.INPUT_SIZE(36), .NCH(2), .LATENCY(4), .ADDR_WIDTH(6),
                 .FILTER_ONES(1), .FILTER_ZEROS(0)) u_dut_b (
    .clk(clk), .reset(reset), .en_proc(en_proc), .start(start), .done(done_b),
    .data_in(data_in), .data_out(dout_b), .wr_en(we_b), .wr_addr(wa_b),
    .overflow(ovf_b));

  prep_mem_nch #(.INPUT_SIZE(36), .NCH(2), .LATENCY(4), .ADDR_WIDTH(2),
                 .FILTER_ONES(1), .FILTER_ZEROS(1)) u_dut_c (
    .clk(clk), .reset(reset), .en_proc(en_proc), .start(start), .done(done_c),
    .data_in(data_in), .data_out(dout_c), .wr_en(we_c), .wr_addr(wa_c),
    .overflow(ovf_c));

  task automatic tick(input logic e, input logic [1:0] s,
                      input logic [35:0] d0, input logic [35:0] d1);
    en_proc = e;
    start   = s;
    data_in = {d1, d0};
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  localparam logic [35:0] ONES = 36'hFFFFFFFFF;

  initial begin
    reset = 1'b0;
    tick(1'b0, 2'd0, '0, '0);
    tick(1'b0, 2'd0, '0, '0);
    chk("rst_done",  72'(done_a), 72'h0);
    chk("rst_dout",  dout_a, 72'h0);
    chk("rst_we",    72'(we_a), 72'h0);
    chk("rst_addr",  72'(wa_a), 72'h0);
    chk("rst_ovf",   72'(ovf_a), 72'h0);
    reset = 1'b1;

    // Event page 1: ch0 all valid, ch1 sentinel / zero / valid
    tick(1'b1, 2'd1, 36'h5, ONES);
    tick(1'b1, 2'd1, 36'h6, 36'h0);
    tick(1'b1, 2'd1, 36'h7, 36'h9);
    tick(1'b0, 2'd1, '0, '0);
    chk("p1v0_done",  72'(done_a), 72'h1);
    chk("p1v0_we_a",  72'(we_a), 72'h1);
    chk("p1v0_a0",    72'(wa_a[7:0]), 72'h40);
    chk("p1v0_a1",    72'(wa_a[15:8]), 72'h00);
    chk("p1v0_dout",  dout_a, {ONES, 36'h5});
    chk("p1v0_we_b",  72'(we_b), 72'h1);
    tick(1'b0, 2'd1, '0, '0);
    chk("p1v1_we_a",  72'(we_a), 72'h1);
    chk("p1v1_a0",    72'(wa_a[7:0]), 72'h41);
    chk("p1v1_dout",  dout_a, {36'h0, 36'h6});
    chk("p1v1_we_b",  72'(we_b), 72'h3);
    chk("p1v1_b1",    72'(wa_b[15:8]), 72'h40);
    tick(1'b0, 2'd1, '0, '0);
    chk("p1v2_we_a",  72'(we_a), 72'h3);
    chk("p1v2_a0",    72'(wa_a[7:0]), 72'h42);
    chk("p1v2_a1",    72'(wa_a[15:8]), 72'h40);
    chk("p1v2_we_b",  72'(we_b), 72'h3);
    chk("p1v2_b1",    72'(wa_b[15:8]), 72'h41);

    // en_proc low for the middle word: no write, count holds
    tick(1'b1, 2'd1, 36'hA, '0);
    tick(1'b0, 2'd1, 36'hB, '0);
    tick(1'b1, 2'd1, 36'hC, '0);
    tick(1'b0, 2'd1, '0, '0);
    chk("en0_we",  72'(we_a), 72'h1);
    chk("en0_a0",  72'(wa_a[7:0]), 72'h43);
    tick(1'b0, 2'd1, '0, '0);
    chk("en1_we",  72'(we_a), 72'h0);
    chk("en1_a0",  72'(wa_a[7:0]), 72'h43);
    chk("en1_a1",  72'(wa_a[15:8]), 72'h40);
    chk("en1_dout", dout_a, {36'h0, 36'hB});
    tick(1'b0, 2'd1, '0, '0);
    chk("en2_we",  72'(we_a), 72'h1);
    chk("en2_a0",  72'(wa_a[7:0]), 72'h44);

    // Page 3: six words into a depth-4 event, then page 2 boundary
    tick(1'b1, 2'd3, 36'h1, '0);
    tick(1'b1, 2'd3, 36'h2, '0);
    tick(1'b1, 2'd3, 36'h3, '0);
    tick(1'b1, 2'd3, 36'h4, '0);
    chk("ov1_we_c",  72'(we_c), 72'h1);
    chk("ov1_c0",    72'(wa_c[3:0]), 72'hC);
    chk("ov1_ovf_c", 72'(ovf_c), 72'h0);
    chk("ov1_a0",    72'(wa_a[7:0]), 72'hC0);
    tick(1'b1, 2'd3, 36'h5, '0);
    chk("ov2_c0",    72'(wa_c[3:0]), 72'hD);
    tick(1'b1, 2'd3, 36'h6, '0);
    chk("ov3_c0",    72'(wa_c[3:0]), 72'hE);
    tick(1'b1, 2'd2, 36'h7, '0);
    chk("ov4_we_c",  72'(we_c), 72'h1);
    chk("ov4_c0",    72'(wa_c[3:0]), 72'hF);
    chk("ov4_ovf_c", 72'(ovf_c), 72'h0);
    tick(1'b0, 2'd2, '0, '0);
    chk("ov5_we_c",  72'(we_c), 72'h0);
    chk("ov5_c0",    72'(wa_c[3:0]), 72'hF);
    chk("ov5_ovf_c", 72'(ovf_c), 72'h1);
    tick(1'b0, 2'd2, '0, '0);
    chk("ov6_we_c",  72'(we_c), 72'h0);
    chk("ov6_ovf_c", 72'(ovf_c), 72'h1);
    chk("ov6_a0",    72'(wa_a[7:0]), 72'hC5);
    chk("ov6_ovf_a", 72'(ovf_a), 72'h0);
    tick(1'b0, 2'd2, '0, '0);
    chk("bnd_we_c",  72'(we_c), 72'h1);
    chk("bnd_c0",    72'(wa_c[3:0]), 72'h8);
    chk("bnd_ovf_c", 72'(ovf_c), 72'h0);
    chk("bnd_a0",    72'(wa_a[7:0]), 72'h80);
    chk("bnd_done",  72'(done_a), 72'h2);

    // Reset pulse with three words in flight
    tick(1'b1, 2'd2, 36'h11, '0);
    tick(1'b1, 2'd2, 36'h12, '0);
    tick(1'b1, 2'd2, 36'h13, '0);
    reset = 1'b0;
    tick(1'b0, 2'd0, '0, '0);
    reset = 1'b1;
    chk("mr_we",   72'(we_a), 72'h0);
    chk("mr_addr", 72'(wa_a), 72'h0);
    chk("mr_dout", dout_a, 72'h0);
    chk("mr_done", 72'(done_a), 72'h0);
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 2'd0, '0, '0);
      chk($sformatf("post_rst%0d_we", k),   72'(we_a), 72'h0);
      chk($sformatf("post_rst%0d_dout", k), dout_a, 72'h0);
      chk($sformatf("post_rst%0d_addr", k), 72'(wa_a), 72'h0);
    end

    // Page 0 after reset is not a boundary and starts at index 0
    tick(1'b1, 2'd0, 36'h21, '0);
    tick(1'b1, 2'd0, 36'h22, '0);
    tick(1'b0, 2'd0, '0, '0);
    tick(1'b0, 2'd0, '0, '0);
    chk("pg0_we0",   72'(we_a), 72'h1);
    chk("pg0_a0",    72'(wa_a[7:0]), 72'h00);
    chk("pg0_dout",  dout_a, {36'h0, 36'h21});
    tick(1'b0, 2'd0, '0, '0);
    chk("pg0_we1",   72'(we_a), 72'h1);
    chk("pg0_a1",    72'(wa_a[7:0]), 72'h01);
    chk("pg0_done",  72'(done_a), 72'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
